// File: rtl/risc_pkg.sv
// Shared datapath definitions for the RISC register file and its helpers.
// Default widths match the original fixed 16x32 bank.
package risc_pkg;
   localparam int DATA_W_DEF     = 32;
   localparam int NUM_REGS_DEF   = 16;
   localparam int REG_ADDR_W_DEF = 4;
   localparam int ZERO_IDX       = 0;

   typedef logic [REG_ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [DATA_W_DEF-1:0]     reg_data_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: set on allocate, cleared on writeback.
// Allocate beats a same-cycle writeback to the same register.
module reg_scoreboard
   import risc_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int ZERO_REG = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic                alloc_en,
   input  logic [ADDR_W-1:0]   alloc_addr,
   output logic [NUM_REGS-1:0] pending,
   output logic                any_pending
);

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (ZERO_REG != 0 && i == ZERO_IDX)
               pending[i] <= 1'b0;
            else if (alloc_en && alloc_addr == ADDR_W'(i))
               pending[i] <= 1'b1;
            else if (wr_en && wr_addr == ADDR_W'(i))
               pending[i] <= 1'b0;
         end
      end
   end

   assign any_pending = |pending;

endmodule

// File: rtl/register_bank_param.sv
// Parametrised register bank with write bypass and pending scoreboard.
// Out-of-range and hardwired-zero registers read as 0, never pending.
module register_bank_param
   import risc_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_pending,
   input  logic                     alloc_en,
   input  logic [ADDR_W-1:0]        alloc_addr,
   output logic                     any_pending
);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] pending;

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rst)
            regs[i] <= '0;
         else if (wr_en && wr_addr == ADDR_W'(i) &&
                  !(ZERO_REG != 0 && i == ZERO_IDX))
            regs[i] <= wr_data;
      end
   end

   reg_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .alloc_en    (alloc_en),
      .alloc_addr  (alloc_addr),
      .pending     (pending),
      .any_pending (any_pending)
   );

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              in_range;
      logic              is_zero;
      logic              hit;
      logic [DATA_W-1:0] d;
      logic              p;

      assign ra       = rd_addr[g*ADDR_W +: ADDR_W];
      assign in_range = 32'(ra) < NUM_REGS;
      assign is_zero  = (ZERO_REG != 0) && ra == ADDR_W'(ZERO_IDX);
      assign hit      = (BYPASS != 0) && wr_en && wr_addr == ra;

      // a forwarded write is by definition no longer pending
      always_comb begin
         d = '0;
         p = 1'b0;
         if (in_range && !is_zero) begin
            if (hit) begin
               d = wr_data;
            end else begin
               d = regs[ra];
               p = pending[ra];
            end
         end
      end

      assign rd_data[g*DATA_W +: DATA_W] = d;
      assign rd_pending[g]               = p;
   end

endmodule
